auto_drive_ctrl: RTL

AUTO_DRIVE_CTRL -- requirements
Module: auto_drive_ctrl

---
 rtl/auto_drive_ctrl_if.sv | 29 ++
 rtl/auto_drive_ctrl.sv | 126 ++++++++++++
 2 files changed

// File: rtl/auto_drive_ctrl_if.sv
// Bundle of the semi-auto drive controller's mode, sensor, button and status signals.
// The controller connects through the slave modport; the stimulus side uses the master modport.
interface auto_drive_ctrl_if;
   logic       enable;
   logic       front_detector;
   logic       left_detector;
   logic       right_detector;
   logic       back_detector;
   logic       cmd_forward;
   logic       cmd_left;
   logic       cmd_right;
   logic       cmd_back;
   logic [3:0] moving_state;
   logic       busy;
   logic [2:0] state_code;
   logic [7:0] decision_cnt;

   modport master (
      output enable, front_detector, left_detector, right_detector, back_detector,
      output cmd_forward, cmd_left, cmd_right, cmd_back,
      input  moving_state, busy, state_code, decision_cnt
   );

   modport slave (
      input  enable, front_detector, left_detector, right_detector, back_detector,
      input  cmd_forward, cmd_left, cmd_right, cmd_back,
      output moving_state, busy, state_code, decision_cnt
   );
endinterface

// File: rtl/auto_drive_ctrl.sv
// Semi-automatic drive controller: settles, decides a move from the obstacle
// detectors, times forward steps and turns, and waits for user buttons when ambiguous.
module auto_drive_ctrl #(
   parameter int SETTLE_CYCLES = 10_000_000,
   parameter int TURN_CYCLES   = 90_000_000,
   parameter int STEP_CYCLES   = 50_000_000
) (
   input  logic             sys_clk,
   input  logic             rst,
   auto_drive_ctrl_if.slave bus
);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] SETTLE    = 3'd1;
   localparam logic [2:0] FWD       = 3'd2;
   localparam logic [2:0] WAIT_CMD  = 3'd3;
   localparam logic [2:0] TURN_L    = 3'd4;
   localparam logic [2:0] TURN_R    = 3'd5;
   localparam logic [2:0] TURN_BACK = 3'd6;

   localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
   localparam logic [31:0] STEP_LAST   = 32'(STEP_CYCLES - 1);
   localparam logic [31:0] TURN_LAST   = 32'(TURN_CYCLES - 1);
   localparam logic [31:0] BACK_LAST   = 32'(2 * TURN_CYCLES - 1);

   logic [2:0]  r_state;
   logic [31:0] r_cnt;
   logic [3:0]  r_moving;
   logic [7:0]  r_dec_cnt;
   logic [3:0]  r_cmd_prev;

   logic [2:0]  w_next;
   logic [3:0]  w_moving_next;
   logic        w_decide;
   logic        w_timed;
   logic [3:0]  w_cmd;
   logic [3:0]  w_edge;
   logic [2:0]  w_flr;
   logic        w_unused_back;

   // Command bit order: 0 forward, 1 left, 2 right, 3 back.
   assign w_cmd  = {bus.cmd_back, bus.cmd_right, bus.cmd_left, bus.cmd_forward};
   assign w_edge = w_cmd & ~r_cmd_prev;
   assign w_flr  = {bus.front_detector, bus.left_detector, bus.right_detector};
   assign w_unused_back = bus.back_detector;

   assign w_timed = (r_state == SETTLE) || (r_state == FWD) || (r_state == TURN_L) ||
                    (r_state == TURN_R) || (r_state == TURN_BACK);

   always_comb begin
      w_next   = r_state;
      w_decide = 1'b0;
      if (!bus.enable) begin
         w_next = IDLE;
      end else begin
         case (r_state)
            IDLE: w_next = SETTLE;
            SETTLE: begin
               if (r_cnt == SETTLE_LAST) begin
                  w_decide = 1'b1;
                  case (w_flr)
                     3'b011:  w_next = FWD;
                     3'b111:  w_next = TURN_BACK;
                     3'b101:  w_next = TURN_L;
                     3'b110:  w_next = TURN_R;
                     default: w_next = WAIT_CMD;
                  endcase
               end
            end
            FWD: begin
               if (bus.front_detector || (r_cnt == STEP_LAST)) w_next = SETTLE;
            end
            WAIT_CMD: begin
               // Blocked directions fall through to the next lower-priority button.
               if (w_edge[0] && !bus.front_detector)      w_next = FWD;
               else if (w_edge[1] && !bus.left_detector)  w_next = TURN_L;
               else if (w_edge[2] && !bus.right_detector) w_next = TURN_R;
               else if (w_edge[3])                        w_next = TURN_BACK;
               w_decide = (w_next != WAIT_CMD);
            end
            TURN_L, TURN_R: begin
               if (r_cnt == TURN_LAST) w_next = FWD;
            end
            TURN_BACK: begin
               if (r_cnt == BACK_LAST) w_next = FWD;
            end
            default: w_next = IDLE;
         endcase
      end
   end

   always_comb begin
      case (w_next)
         FWD:               w_moving_next = 4'b0001;
         TURN_L, TURN_BACK: w_moving_next = 4'b0100;
         TURN_R:            w_moving_next = 4'b1000;
         default:           w_moving_next = 4'b0000;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_cnt      <= 32'd0;
         r_moving   <= 4'b0000;
         r_dec_cnt  <= 8'd0;
         r_cmd_prev <= 4'b0000;
      end else begin
         r_state    <= w_next;
         r_moving   <= w_moving_next;
         r_cmd_prev <= w_cmd;
         if (w_next != r_state)
            r_cnt <= 32'd0;
         else if (w_timed)
            r_cnt <= r_cnt + 32'd1;
         if (w_decide)
            r_dec_cnt <= r_dec_cnt + 8'd1;
      end
   end

   assign bus.moving_state = r_moving;
   assign bus.state_code   = r_state;
   assign bus.decision_cnt = r_dec_cnt;
   assign bus.busy         = w_timed;

endmodule
